// File: rtl/composite_pkg.sv
// Shared types and default ladder codes for the composite test-pattern generator.
package composite_pkg;

  localparam int unsigned MODE_BITS = 3;

  typedef enum logic [MODE_BITS-1:0] {
    MODE_SOLID   = 3'd0,
    MODE_VBARS   = 3'd1,
    MODE_HBARS   = 3'd2,
    MODE_CHECKER = 3'd3,
    MODE_RAMP    = 3'd4,
    MODE_SCROLL  = 3'd5
  } mode_t;

  // Default codes for the 3-resistor ladder
  localparam logic [2:0] DEF_LEVEL_SYNC  = 3'd0;
  localparam logic [2:0] DEF_LEVEL_BLANK = 3'd1;
  localparam logic [2:0] DEF_LEVEL_BLACK = 3'd1;
  localparam logic [2:0] DEF_LEVEL_WHITE = 3'd6;

endpackage

// File: rtl/composite_position_counter.sv
// Horizontal pixel counter, vsync rising-edge detect and frame counter.
module composite_position_counter #(
  parameter int unsigned X_BITS     = 9,
  parameter int unsigned FRAME_BITS = 8
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  hsync,
  input  logic                  vsync,
  output logic [X_BITS-1:0]     x,
  output logic [FRAME_BITS-1:0] frame_cnt,
  output logic                  frame_start,
  output logic                  vsync_rise
);

  logic vsync_q;

  // Combinational so the mode register can load on the same edge
  assign vsync_rise = vsync & ~vsync_q;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= '0;
      vsync_q     <= 1'b0;
      frame_cnt   <= '0;
      frame_start <= 1'b0;
    end else begin
      x           <= hsync ? '0 : x + X_BITS'(1);
      vsync_q     <= vsync;
      frame_start <= vsync_rise;
      if (vsync_rise) begin
        frame_cnt <= frame_cnt + FRAME_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/composite_pattern_gen.sv
// Composite test-pattern generator: frame-synchronous mode register, pattern
// mux and registered DAC output with sync/blank priority.
module composite_pattern_gen
  import composite_pkg::*;
#(
  parameter int unsigned DAC_BITS   = 3,
  parameter int unsigned X_BITS     = 9,
  parameter int unsigned Y_BITS     = 10,
  parameter int unsigned X_SHIFT    = 6,
  parameter int unsigned Y_SHIFT    = 4,
  parameter int unsigned RAMP_SHIFT = 5,
  parameter logic [DAC_BITS-1:0] LEVEL_SYNC  = DAC_BITS'(DEF_LEVEL_SYNC),
  parameter logic [DAC_BITS-1:0] LEVEL_BLANK = DAC_BITS'(DEF_LEVEL_BLANK),
  parameter logic [DAC_BITS-1:0] LEVEL_BLACK = DAC_BITS'(DEF_LEVEL_BLACK),
  parameter logic [DAC_BITS-1:0] LEVEL_WHITE = DAC_BITS'(DEF_LEVEL_WHITE),
  parameter int unsigned FRAME_BITS = 8
) (
  input  logic                 refclk,
  input  logic                 rst_n,
  input  logic                 hsync,
  input  logic                 vsync,
  input  logic                 hblank,
  input  logic                 vblank,
  input  logic                 active_video,
  input  logic [Y_BITS-1:0]    y,
  input  logic [MODE_BITS-1:0] mode_req,
  output logic [DAC_BITS-1:0]  dac,
  output logic [MODE_BITS-1:0] mode_active,
  output logic                 frame_start
);

  localparam int unsigned SUM_W = DAC_BITS + X_BITS;

  logic [X_BITS-1:0]     x;
  logic [FRAME_BITS-1:0] frame_cnt;
  logic                  vsync_rise;
  logic [MODE_BITS-1:0]  mode_q;
  logic                  x_bit;
  logic                  y_bit;
  logic                  scroll_bit;
  logic [SUM_W-1:0]      ramp_sum;
  logic [DAC_BITS-1:0]   pattern_level;
  logic [DAC_BITS-1:0]   dac_next;

  composite_position_counter #(
    .X_BITS     (X_BITS),
    .FRAME_BITS (FRAME_BITS)
  ) u_position (
    .refclk      (refclk),
    .rst_n       (rst_n),
    .hsync       (hsync),
    .vsync       (vsync),
    .x           (x),
    .frame_cnt   (frame_cnt),
    .frame_start (frame_start),
    .vsync_rise  (vsync_rise)
  );

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_SOLID;
    end else if (vsync_rise) begin
      mode_q <= mode_req;
    end
  end

  assign mode_active = mode_q;

  assign x_bit = x[X_SHIFT];
  assign y_bit = y[Y_SHIFT];
  // Row select of the scrolled line; the Y_BITS-wide sum wraps naturally
  assign scroll_bit = |((y + Y_BITS'(frame_cnt)) & (Y_BITS'(1) << Y_SHIFT));
  // Wide enough that the sum can never wrap before saturation
  assign ramp_sum = SUM_W'(LEVEL_BLACK) + SUM_W'(x >> RAMP_SHIFT);

  always_comb begin
    pattern_level = LEVEL_BLACK;
    case (mode_q)
      MODE_SOLID:   pattern_level = LEVEL_WHITE;
      MODE_VBARS:   pattern_level = x_bit ? LEVEL_WHITE : LEVEL_BLACK;
      MODE_HBARS:   pattern_level = y_bit ? LEVEL_WHITE : LEVEL_BLACK;
      MODE_CHECKER: pattern_level = (x_bit ^ y_bit) ? LEVEL_WHITE : LEVEL_BLACK;
      MODE_RAMP: begin
        if (ramp_sum > SUM_W'(LEVEL_WHITE)) begin
          pattern_level = LEVEL_WHITE;
        end else begin
          pattern_level = ramp_sum[DAC_BITS-1:0];
        end
      end
      MODE_SCROLL:  pattern_level = (x_bit ^ scroll_bit) ? LEVEL_WHITE : LEVEL_BLACK;
      default:      pattern_level = LEVEL_BLACK;
    endcase
  end

  always_comb begin
    dac_next = LEVEL_BLANK;
    if (hsync | vsync) begin
      dac_next = LEVEL_SYNC;
    end else if (hblank | vblank) begin
      dac_next = LEVEL_BLANK;
    end else if (active_video) begin
      dac_next = pattern_level;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      dac <= LEVEL_SYNC;
    end else begin
      dac <= dac_next;
    end
  end

endmodule

// File: tb/tb_composite_pattern_gen.sv
// Self-checking bench for composite_pattern_gen with a behavioural model of
// the pattern rules at default parameters.
module tb_composite_pattern_gen;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       hsync, vsync, hblank, vblank, active_video;
  logic [9:0] y;
  logic [2:0] mode_req;
  logic [2:0] dac;
  logic [2:0] mode_active;
  logic       frame_start;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  int m_x, m_mode, m_fc, m_vq, m_fs;
  int exp_dac;

  always #5 refclk = ~refclk;

  composite_pattern_gen dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .hsync        (hsync),
    .vsync        (vsync),
    .hblank       (hblank),
    .vblank       (vblank),
    .active_video (active_video),
    .y            (y),
    .mode_req     (mode_req),
    .dac          (dac),
    .mode_active  (mode_active),
    .frame_start  (frame_start)
  );

  function automatic int pattern_level(int mode, int x, int yy, int fc);
    int xb, yb, sb, r;
    xb = (x / 64) % 2;
    yb = (yy / 16) % 2;
    sb = (((yy + fc) % 1024) / 16) % 2;
    case (mode)
      0: return 6;
      1: return xb ? 6 : 1;
      2: return yb ? 6 : 1;
      3: return (xb != yb) ? 6 : 1;
      4: begin
        r = 1 + x / 32;
        return (r > 6) ? 6 : r;
      end
      5: return (xb != sb) ? 6 : 1;
      default: return 1;
    endcase
  endfunction

  task automatic model_reset();
    m_x = 0; m_mode = 0; m_fc = 0; m_vq = 0; m_fs = 0;
  endtask

  // Predict this edge's dac from current inputs, clock, then advance the model.
  task automatic step();
    if (hsync || vsync)          exp_dac = 0;
    else if (hblank || vblank)   exp_dac = 1;
    else if (active_video)       exp_dac = pattern_level(m_mode, m_x, int'(y), m_fc);
    else                         exp_dac = 1;
    @(posedge refclk);
    #1;
    m_x = hsync ? 0 : (m_x + 1) % 512;
    if (vsync && m_vq == 0) begin
      m_fs = 1;
      m_mode = int'(mode_req);
      m_fc = (m_fc + 1) % 256;
    end else begin
      m_fs = 0;
    end
    m_vq = vsync ? 1 : 0;
  endtask

  task automatic idle_inputs();
    hsync = 0; vsync = 0; hblank = 0; vblank = 0; active_video = 0; y = '0;
  endtask

  // Vsync pulse to load a mode, then one hsync cycle to zero x.
  task automatic enter_mode(input int mode);
    idle_inputs();
    mode_req = 3'(mode);
    vsync = 1; step();
    vsync = 0; hsync = 1; step();
    hsync = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    mode_req = 3'd0;
    rst_n = 0;
    model_reset();
    repeat (3) @(posedge refclk);
    #1;
    n_checks++;
    if (dac !== 3'd0) begin
      n_errors++; $display("FAIL reset_dac got=%0d want=0", dac);
    end
    n_checks++;
    if (mode_active !== 3'd0) begin
      n_errors++; $display("FAIL reset_mode got=%0d want=0", mode_active);
    end
    n_checks++;
    if (frame_start !== 1'b0) begin
      n_errors++; $display("FAIL reset_frame_start got=%0d want=0", frame_start);
    end
    rst_n = 1;
    enter_mode(1);
    active_video = 1;
    repeat (5) step();
    n_checks++;
    if (dac !== 3'd1) begin
      n_errors++; $display("FAIL reset_pre_vbar got=%0d want=1", dac);
    end
    #3 rst_n = 0;
    #1;
    n_checks++;
    if (dac !== 3'd0) begin
      n_errors++; $display("FAIL reset_async_dac got=%0d want=0", dac);
    end
    n_checks++;
    if (mode_active !== 3'd0) begin
      n_errors++; $display("FAIL reset_async_mode got=%0d want=0", mode_active);
    end
    @(posedge refclk);
    #1;
    rst_n = 1;
    model_reset();
    step();
    n_checks++;
    if (dac !== 3'd6) begin
      n_errors++; $display("FAIL reset_release_dac got=%0d want=6", dac);
    end
  endtask

  task automatic test_priority();
    idle_inputs();
    hsync = 1; hblank = 1; active_video = 1;
    step();
    n_checks++;
    if (dac !== 3'd0) begin
      n_errors++; $display("FAIL prio_sync got=%0d want=0", dac);
    end
    hsync = 0;
    step();
    n_checks++;
    if (dac !== 3'd1) begin
      n_errors++; $display("FAIL prio_blank got=%0d want=1", dac);
    end
    hblank = 0;
    step();
    n_checks++;
    if (dac !== 3'd6) begin
      n_errors++; $display("FAIL prio_active got=%0d want=6", dac);
    end
    active_video = 0;
    step();
    n_checks++;
    if (dac !== 3'd1) begin
      n_errors++; $display("FAIL prio_idle got=%0d want=1", dac);
    end
  endtask

  task automatic test_vbars();
    int want;
    enter_mode(1);
    active_video = 1;
    for (int k = 0; k < 256; k++) begin
      step();
      want = ((k / 64) % 2) ? 6 : 1;
      n_checks++;
      if (dac !== 3'(want)) begin
        n_errors++; $display("FAIL vbars k=%0d got=%0d want=%0d", k, dac, want);
      end
    end
    idle_inputs();
  endtask

  task automatic test_ramp();
    int want;
    enter_mode(4);
    active_video = 1;
    for (int k = 0; k < 320; k++) begin
      step();
      want = 1 + k / 32;
      if (want > 6) want = 6;
      n_checks++;
      if (dac !== 3'(want)) begin
        n_errors++; $display("FAIL ramp k=%0d got=%0d want=%0d", k, dac, want);
      end
    end
    idle_inputs();
  endtask

  task automatic test_frame_mode();
    enter_mode(3);
    active_video = 1;
    for (int k = 0; k < 20; k++) begin
      if (k == 5) mode_req = 3'd2;
      step();
      n_checks++;
      if (mode_active !== 3'd3 || frame_start !== 1'b0) begin
        n_errors++;
        $display("FAIL frame_hold k=%0d got mode=%0d fs=%0d want mode=3 fs=0", k, mode_active, frame_start);
      end
    end
    vsync = 1;
    step();
    n_checks++;
    if (mode_active !== 3'd2 || frame_start !== 1'b1 || dac !== 3'd0) begin
      n_errors++;
      $display("FAIL frame_switch got mode=%0d fs=%0d dac=%0d want mode=2 fs=1 dac=0", mode_active, frame_start, dac);
    end
    step();
    n_checks++;
    if (frame_start !== 1'b0 || mode_active !== 3'd2) begin
      n_errors++;
      $display("FAIL frame_pulse_width got fs=%0d mode=%0d want fs=0 mode=2", frame_start, mode_active);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_scroll();
    int want;
    int phase0, phase16;
    phase0 = -1; phase16 = -1;
    for (int f = 0; f < 272; f++) begin
      idle_inputs();
      mode_req = 3'd5;
      vsync = 1; step();
      n_checks++;
      if (frame_start !== 1'b1) begin
        n_errors++; $display("FAIL scroll_fs f=%0d got=%0d want=1", f, frame_start);
      end
      vsync = 0; hsync = 1; step();
      hsync = 0; active_video = 1; y = '0; step();
      want = ((m_fc / 16) % 2) ? 6 : 1;
      n_checks++;
      if (dac !== 3'(want)) begin
        n_errors++; $display("FAIL scroll f=%0d fc=%0d got=%0d want=%0d", f, m_fc, dac, want);
      end
      if (m_fc == 0)  phase0  = int'(dac);
      if (m_fc == 16) phase16 = int'(dac);
    end
    n_checks++;
    if (phase0 != 1 || phase16 != 6) begin
      n_errors++; $display("FAIL scroll_invert got fc0=%0d fc16=%0d want fc0=1 fc16=6", phase0, phase16);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_random();
    for (int k = 0; k < 4000; k++) begin
      hsync        = ($urandom % 200) == 0;
      vsync        = ($urandom % 60) == 0;
      hblank       = ($urandom % 10) == 0;
      vblank       = ($urandom % 10) == 0;
      active_video = ($urandom % 4) != 0;
      y            = 10'($urandom_range(0, 1023));
      mode_req     = 3'($urandom_range(0, 7));
      step();
      n_checks++;
      if (dac !== 3'(exp_dac) || mode_active !== 3'(m_mode) || frame_start !== 1'(m_fs)) begin
        n_errors++;
        $display("FAIL random k=%0d got dac=%0d mode=%0d fs=%0d want dac=%0d mode=%0d fs=%0d",
                 k, dac, mode_active, frame_start, exp_dac, m_mode, m_fs);
      end
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    // Vsync held high for several cycles must give a single pulse.
    idle_inputs();
    step();
    mode_req = 3'd4;
    vsync = 1;
    step();
    n_checks++;
    if (frame_start !== 1'b1 || mode_active !== 3'd4) begin
      n_errors++; $display("FAIL b2b_first got fs=%0d mode=%0d want fs=1 mode=4", frame_start, mode_active);
    end
    mode_req = 3'd1;
    repeat (3) begin
      step();
      n_checks++;
      if (frame_start !== 1'b0 || mode_active !== 3'd4) begin
        n_errors++; $display("FAIL b2b_hold got fs=%0d mode=%0d want fs=0 mode=4", frame_start, mode_active);
      end
    end
    vsync = 0; step();
    vsync = 1; step();
    n_checks++;
    if (frame_start !== 1'b1 || mode_active !== 3'd1) begin
      n_errors++; $display("FAIL b2b_second got fs=%0d mode=%0d want fs=1 mode=1", frame_start, mode_active);
    end
    idle_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_vbars();
    test_ramp();
    test_frame_mode();
    test_scroll();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/composite_pattern_gen.md
# composite_pattern_gen

Parametrised composite-video test-pattern generator driving an N-bit resistor-ladder DAC. It sits between the composite timing generator and the output pins, and converts the sync, blank and active-video strobes plus the line number into registered DAC codes. It supports six selectable patterns and configurable level codes. Mode changes are frame-synchronous, and one pattern scrolls under the control of a frame counter.

## Interface
- `DAC_BITS`, 3: DAC code width (one bit per ladder resistor).
- `X_BITS`, 9: horizontal pixel counter width.
- `Y_BITS`, 10: line number width.
- `X_SHIFT`, 6: x bit selecting vertical bar / checker column.
- `Y_SHIFT`, 4: y bit selecting horizontal bar / checker row.
- `RAMP_SHIFT`, 5: right shift applied to x for ramp mode.
- `LEVEL_SYNC`, 0: DAC code during sync.
- `LEVEL_BLANK`, 1: DAC code during blanking.
- `LEVEL_BLACK`, 1: DAC code for pattern "dark".
- `LEVEL_WHITE`, 6: DAC code for pattern "bright".
- `FRAME_BITS`, 8: frame counter width.

Ports:
- `refclk`  in  1  sole clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `hsync`, `vsync`, `hblank`, `vblank`, `active_video`  in  1 each  timing strobes, synchronous to `refclk`.
- `y`  in  `Y_BITS`  current line number.
- `mode_req`  in  3  requested pattern mode.
- `dac`  out  `DAC_BITS`  registered DAC code.
- `mode_active`  out  3  mode currently in effect.
- `frame_start`  out  1  one-cycle pulse on each vsync rising edge.

## Operation
- **x counter:** cleared on any cycle with `hsync`=1; otherwise increments. It wraps modulo 2^`X_BITS`.
- **vsync edge detect:** `vsync_q` is a registered copy of `vsync`. A rising edge is `vsync & ~vsync_q`.
- **On each rising edge:**
  - `frame_start` is asserted for that cycle.
  - `mode_active` is loaded with `mode_req`.
  - `frame_cnt` increments and wraps.
- `mode_req` changes at any other time have no effect until the next rising edge.
- **Level priority, evaluated per cycle:**
  1. `hsync | vsync` → `LEVEL_SYNC`.
  2. `hblank | vblank` → `LEVEL_BLANK`.
  3. `active_video` → pattern level.
  4. Otherwise → `LEVEL_BLANK`.
- **Pattern level by `mode_active`:**
  - 0 solid: `LEVEL_WHITE`.
  - 1 vertical bars: `x[X_SHIFT]` ? WHITE : BLACK.
  - 2 horizontal bars: `y[Y_SHIFT]` ? WHITE : BLACK.
  - 3 checker: `x[X_SHIFT] ^ y[Y_SHIFT]` ? WHITE : BLACK.
  - 4 ramp: `LEVEL_BLACK + (x >> RAMP_SHIFT)`. The sum is computed at width `DAC_BITS+X_BITS` and saturated to `LEVEL_WHITE`. It never exceeds `LEVEL_WHITE` and never wraps.
  - 5 scrolling checker: same as mode 3, but using `(y + frame_cnt)[Y_SHIFT]`. The addition is at `Y_BITS` width and wraps.
  - 6, 7 reserved: `LEVEL_BLACK`.

## Timing
- **Reset values:**
  - `dac` = `LEVEL_SYNC`
  - `mode_active` = 0
  - `frame_start` = 0
  - x counter = 0
  - `frame_cnt` = 0
  - `vsync_q` = 0
- **Output latency:**
  - `dac` reflects the timing inputs and `y` sampled on edge N, and is valid after edge N.
  - Pattern modes use the x counter value from *before* edge N. With `hsync` low, x = 0 on the first cycle after `hsync` deasserts.
- **Frame-boundary latency:**
  - `frame_start`, `mode_active` and `frame_cnt` update on the edge that samples the vsync rising edge.
  - That same edge's `dac` uses the *old* `mode_active`. This is harmless because vsync forces `LEVEL_SYNC`.
- **Simultaneous events:** `hsync` during active video forces sync, and the x counter clears on the same edge.
- **Wrap:** `frame_cnt` wraps from 2^`FRAME_BITS`−1 to 0 with no glitch in `frame_start`.
- **Reset mid-line:** `dac` goes to `LEVEL_SYNC` immediately (asynchronous). After `rst_n` releases, operation resumes on the next edge with x = 0 and mode 0.

## Structure
- **Shared package `composite_pkg`:**
  - mode enum: `MODE_SOLID`, `MODE_VBARS`, `MODE_HBARS`, `MODE_CHECKER`, `MODE_RAMP`, `MODE_SCROLL`.
  - default level code constants for the 3-bit ladder.
- **Sub-module `composite_position_counter`:** holds the x counter, `vsync` edge detect, `frame_cnt` and `frame_start`.
- **Top:** contains the mode register, pattern mux and output register.

## Test plan
- **Reset:** assert `rst_n`=0 mid-active-video in mode 1 → `dac`=0 within the same cycle and `mode_active`=0. After release with `active_video`=1 → `dac`=6.
- **Priority:** `hsync`=1, `hblank`=1, `active_video`=1 → `dac`=0. Then `hsync`=0 → `dac`=1. Then `hblank`=0 → pattern level.
- **Vertical bars:** mode 1, `X_SHIFT`=6 → the first 64 active cycles after `hsync` drops give `dac`=1, the next 64 give `dac`=6, then repeat.
- **Ramp saturation:** mode 4 → `dac` steps 1,2,3… every 32 cycles and holds at 6 from x=160 onward. No wrap to 0.
- **Frame-synchronous mode:** change `mode_req` 3→2 mid-frame → `mode_active` stays 3 until the vsync rising edge. It switches on that edge, coincident with the 1-cycle `frame_start` pulse.
- **Scroll:** mode 5 → the checker row phase on line 0 inverts after 16 frames. `frame_cnt` wraps 255→0 across 256 frames.
